rv32i_fetch: RTL and testbench

RV32I_FETCH -- requirements
Module: rv32i_fetch

---
 rtl/rv32i_fetch_if.sv | 26 ++
 rtl/rv32i_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_rv32i_fetch.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, execute-stage redirect
// and decoder handshake. master = fetch unit, slave = its environment.
interface rv32i_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_fault;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_fault,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_fault,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I fetch stage: in-order request issue, pc tracking queue and a registered
// instruction buffer. Misaligned-redirect faulting is enabled by RV32I_FETCH_MISALIGN_EN.
module rv32i_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input logic           clk,
   input logic           reset_n,
   rv32i_fetch_if.master bus
);
   localparam int          CW       = $clog2(DEPTH) + 1;
   localparam logic [1:0]  ST_RUN   = 2'd0;
   localparam logic [1:0]  ST_DRAIN = 2'd1;
   localparam logic [1:0]  ST_HALT  = 2'd2;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   logic [1:0]    state_r, state_s;
   logic [31:0]   fetch_pc_r, fetch_pc_s;
   logic          fault_pend_r, fault_pend_s;
   logic          req_valid_r, req_valid_s;
   logic          inst_valid_r;
   logic [CW-1:0] out_r, out_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [31:0]   dat_r [DEPTH];
   logic [31:0]   dat_s [DEPTH];
   logic [31:0]   pc_r  [DEPTH];
   logic [31:0]   pc_s  [DEPTH];
   logic          flt_r [DEPTH];
   logic          flt_s [DEPTH];
   logic [31:0]   pcq_r [DEPTH];
   logic [31:0]   pcq_s [DEPTH];

   logic          accept_s, rsp_take_s, push_s, pop_s, flush_s, misalign_s, push_fault_s;
   logic [31:0]   push_data_s, push_pc_s, redirect_tgt_s;
   logic [CW-1:0] wr_idx_s, pcq_idx_s;

`ifdef RV32I_FETCH_MISALIGN_EN
   assign misalign_s     = (bus.redirect_pc[1:0] != 2'b00);
   assign redirect_tgt_s = bus.redirect_pc;
`else
   assign misalign_s     = 1'b0;
   assign redirect_tgt_s = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

   assign accept_s   = req_valid_r & bus.imem_req_ready;
   assign rsp_take_s = bus.imem_rsp_valid & (out_r != {CW{1'b0}});

   // Next-state control: redirect overrides every other event in the cycle.
   always_comb begin
      state_s      = state_r;
      fetch_pc_s   = fetch_pc_r;
      fault_pend_s = fault_pend_r;
      out_s        = out_r + CW'(accept_s) - CW'(rsp_take_s);
      push_s       = 1'b0;
      pop_s        = 1'b0;
      flush_s      = 1'b0;
      push_data_s  = bus.imem_rsp_data;
      push_pc_s    = pcq_r[0];
      push_fault_s = 1'b0;
      if (bus.redirect_valid) begin
         flush_s      = 1'b1;
         fetch_pc_s   = redirect_tgt_s;
         fault_pend_s = misalign_s;
         if (misalign_s || (out_s != {CW{1'b0}})) begin
            state_s = ST_DRAIN;
         end else begin
            state_s = ST_RUN;
         end
      end else begin
         pop_s = inst_valid_r & bus.inst_ready;
         case (state_r)
            ST_RUN: begin
               push_s = rsp_take_s;
               if (accept_s) begin
                  fetch_pc_s = fetch_pc_r + 32'd4;
               end else begin
                  fetch_pc_s = fetch_pc_r;
               end
            end
            ST_DRAIN: begin
               // A pending fault is only reported once every older response has been dropped.
               if (fault_pend_r) begin
                  if (out_r == {CW{1'b0}}) begin
                     push_s       = 1'b1;
                     push_data_s  = NOP_WORD;
                     push_pc_s    = fetch_pc_r;
                     push_fault_s = 1'b1;
                     fault_pend_s = 1'b0;
                     state_s      = ST_HALT;
                  end else begin
                     state_s = ST_DRAIN;
                  end
               end else if (out_s == {CW{1'b0}}) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_DRAIN;
               end
            end
            ST_HALT: begin
               state_s = ST_HALT;
            end
            default: begin
               state_s = ST_RUN;
            end
         endcase
      end
      if (flush_s) begin
         cnt_s = {CW{1'b0}};
      end else begin
         cnt_s = cnt_r + CW'(push_s) - CW'(pop_s);
      end
      req_valid_s = (state_s == ST_RUN) &&
                    (({1'b0, cnt_s} + {1'b0, out_s}) < (CW+1)'(DEPTH));
   end

   // Instruction buffer as a shift register so the head entry drives inst_* directly.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         dat_s[i] = dat_r[i];
         pc_s[i]  = pc_r[i];
         flt_s[i] = flt_r[i];
      end
      if (pop_s) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            dat_s[i] = dat_r[i+1];
            pc_s[i]  = pc_r[i+1];
            flt_s[i] = flt_r[i+1];
         end
      end else begin
         dat_s[0] = dat_r[0];
      end
      wr_idx_s = cnt_r - CW'(pop_s);
      if (push_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == wr_idx_s) begin
               dat_s[i] = push_data_s;
               pc_s[i]  = push_pc_s;
               flt_s[i] = push_fault_s;
            end else begin
               flt_s[i] = flt_s[i];
            end
         end
      end else begin
         flt_s[0] = flt_s[0];
      end
   end

   // In-order queue of request addresses awaiting their response.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pcq_s[i] = pcq_r[i];
      end
      if (rsp_take_s) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            pcq_s[i] = pcq_r[i+1];
         end
      end else begin
         pcq_s[0] = pcq_r[0];
      end
      pcq_idx_s = out_r - CW'(rsp_take_s);
      if (accept_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == pcq_idx_s) begin
               pcq_s[i] = fetch_pc_r;
            end else begin
               pcq_s[i] = pcq_s[i];
            end
         end
      end else begin
         pcq_s[0] = pcq_s[0];
      end
   end

   // State and storage registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_RUN;
         fetch_pc_r   <= RESET_PC;
         fault_pend_r <= 1'b0;
         req_valid_r  <= 1'b0;
         inst_valid_r <= 1'b0;
         out_r        <= {CW{1'b0}};
         cnt_r        <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            dat_r[i] <= 32'h0000_0000;
            pc_r[i]  <= 32'h0000_0000;
            flt_r[i] <= 1'b0;
            pcq_r[i] <= 32'h0000_0000;
         end
      end else begin
         state_r      <= state_s;
         fetch_pc_r   <= fetch_pc_s;
         fault_pend_r <= fault_pend_s;
         req_valid_r  <= req_valid_s;
         inst_valid_r <= (cnt_s != {CW{1'b0}});
         out_r        <= out_s;
         cnt_r        <= cnt_s;
         for (int i = 0; i < DEPTH; i++) begin
            dat_r[i] <= dat_s[i];
            pc_r[i]  <= pc_s[i];
            flt_r[i] <= flt_s[i];
            pcq_r[i] <= pcq_s[i];
         end
      end
   end

   assign bus.imem_req_valid = req_valid_r;
   assign bus.imem_req_addr  = fetch_pc_r;
   assign bus.inst_valid     = inst_valid_r;
   assign bus.inst_data      = dat_r[0];
   assign bus.inst_pc        = pc_r[0];
   assign bus.inst_fault     = flt_r[0];
endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: streaming, backpressure, redirects, pc wrap and
// misaligned redirect targets, against a 1-cycle-latency memory model.
module tb_rv32i_fetch;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          DEPTH  = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic rsp_en  = 1'b0;
   int   n_vec   = 0;
   int   n_err   = 0;
   int   cyc     = 0;
   logic edge_rsp = 1'b0;
   logic edge_hs  = 1'b0;

   logic [31:0] mem_q[$];
   logic [31:0] acc_q[$];
   logic [31:0] cons_pc[$];
   logic [31:0] cons_data[$];
   logic        cons_fault[$];
   int          cons_cyc[$];

   rv32i_fetch_if bus ();

   rv32i_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Edge logger: accepted requests, consumed instructions, memory queue bookkeeping.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q.delete();
      end else begin
         cyc++;
         edge_rsp = bus.imem_rsp_valid;
         edge_hs  = bus.inst_valid && bus.inst_ready;
         if (bus.imem_rsp_valid && mem_q.size() > 0) mem_q.delete(0);
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_q.push_back(bus.imem_req_addr);
            acc_q.push_back(bus.imem_req_addr);
         end
         if (edge_hs && !bus.redirect_valid) begin
            cons_pc.push_back(bus.inst_pc);
            cons_data.push_back(bus.inst_data);
            cons_fault.push_back(bus.inst_fault);
            cons_cyc.push_back(cyc);
         end
      end
   end

   // Memory response driver, one cycle after acceptance, away from the active edge.
   always @(negedge clk) begin
      if (reset_n && rsp_en && mem_q.size() > 0) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(mem_q[0]);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0000_0000;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0000_0000;
      rsp_en = 1'b1;
      repeat (3) tick();
      n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); end
      n_vec++; if (bus.imem_req_addr !== RST_PC) begin n_err++; $display("FAIL rst_req_addr: got %h expected %h", bus.imem_req_addr, RST_PC); end
      n_vec++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b expected 0", bus.inst_valid); end
      n_vec++; if (bus.inst_fault !== 1'b0) begin n_err++; $display("FAIL rst_inst_fault: got %b expected 0", bus.inst_fault); end
      n_vec++; if (bus.inst_data !== 32'h0) begin n_err++; $display("FAIL rst_inst_data: got %h expected 0", bus.inst_data); end
      n_vec++; if (bus.inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h expected 0", bus.inst_pc); end
      reset_n = 1'b1;
      tick();
      n_vec++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid: got %b expected 1", bus.imem_req_valid); end
      n_vec++; if (bus.imem_req_addr !== RST_PC) begin n_err++; $display("FAIL first_req_addr: got %h expected %h", bus.imem_req_addr, RST_PC); end
   endtask

   task automatic test_stream();
      int a0 = acc_q.size();
      int c0 = cons_pc.size();
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      repeat (12) tick();
      n_vec++; if (acc_q.size() < a0 + 8) begin n_err++; $display("FAIL stream_acc_count: got %0d expected >= %0d", acc_q.size() - a0, 8); end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (acc_q[a0+i] !== RST_PC + 32'(4*i)) begin n_err++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, acc_q[a0+i], RST_PC + 32'(4*i)); end
      end
      n_vec++; if (cons_pc.size() < c0 + 6) begin n_err++; $display("FAIL stream_cons_count: got %0d expected >= 6", cons_pc.size() - c0); end
      for (int i = 0; i < 6; i++) begin
         n_vec++; if (cons_pc[c0+i] !== RST_PC + 32'(4*i)) begin n_err++; $display("FAIL stream_inst_pc[%0d]: got %h expected %h", i, cons_pc[c0+i], RST_PC + 32'(4*i)); end
         n_vec++; if (cons_data[c0+i] !== mem_word(RST_PC + 32'(4*i))) begin n_err++; $display("FAIL stream_inst_data[%0d]: got %h expected %h", i, cons_data[c0+i], mem_word(RST_PC + 32'(4*i))); end
      end
      for (int i = 1; i < 6; i++) begin
         n_vec++; if (cons_cyc[c0+i] - cons_cyc[c0+i-1] != 1) begin n_err++; $display("FAIL stream_rate[%0d]: got gap %0d expected 1", i, cons_cyc[c0+i] - cons_cyc[c0+i-1]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held_pc;
      logic [31:0] held_data;
      logic [31:0] exp_pc;
      int c_rel;
      int bad;
      bus.inst_ready = 1'b0;
      tick();
      held_pc   = bus.inst_pc;
      held_data = bus.inst_data;
      exp_pc    = RST_PC + 32'(4*cons_pc.size());
      repeat (9) tick();
      n_vec++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_inst_valid: got %b expected 1", bus.inst_valid); end
      n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_valid_full: got %b expected 0", bus.imem_req_valid); end
      n_vec++; if (acc_q.size() - cons_pc.size() != DEPTH) begin n_err++; $display("FAIL bp_held_entries: got %0d expected %0d", acc_q.size() - cons_pc.size(), DEPTH); end
      n_vec++; if (bus.inst_pc !== held_pc || held_pc !== exp_pc) begin n_err++; $display("FAIL bp_hold_pc: got %h/%h expected %h", held_pc, bus.inst_pc, exp_pc); end
      n_vec++; if (bus.inst_data !== held_data || held_data !== mem_word(exp_pc)) begin n_err++; $display("FAIL bp_hold_data: got %h/%h expected %h", held_data, bus.inst_data, mem_word(exp_pc)); end
      c_rel = cons_pc.size();
      bus.inst_ready = 1'b1;
      repeat (12) tick();
      n_vec++; if (cons_pc.size() - c_rel < DEPTH) begin n_err++; $display("FAIL bp_release_count: got %0d expected >= %0d", cons_pc.size() - c_rel, DEPTH); end
      bad = -1;
      for (int i = 0; i < cons_pc.size(); i++) begin
         if (bad < 0 && (cons_pc[i] !== RST_PC + 32'(4*i) || cons_data[i] !== mem_word(RST_PC + 32'(4*i)))) bad = i;
      end
      n_vec++; if (bad != -1) begin n_err++; $display("FAIL bp_sequence: got break at index %0d expected none", bad); end
   endtask

   task automatic test_redirect_drain();
      int a0;
      int c0;
      reset_n = 1'b0;
      bus.imem_req_ready = 1'b0;
      rsp_en = 1'b0;
      tick();
      n_vec++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_outputs: got req %b inst %b expected 0 0", bus.imem_req_valid, bus.inst_valid); end
      reset_n = 1'b1;
      a0 = acc_q.size();
      c0 = cons_pc.size();
      bus.imem_req_ready = 1'b1;
      for (int k = 0; k < 20 && acc_q.size() < a0 + 2; k++) tick();
      bus.imem_req_ready = 1'b0;
      n_vec++; if (acc_q.size() != a0 + 2) begin n_err++; $display("FAIL drain_setup_count: got %0d expected 2", acc_q.size() - a0); end
      n_vec++; if (acc_q[a0] !== RST_PC || acc_q[a0+1] !== RST_PC + 32'd4) begin n_err++; $display("FAIL drain_setup_addr: got %h %h expected %h %h", acc_q[a0], acc_q[a0+1], RST_PC, RST_PC + 32'd4); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0100;
      rsp_en = 1'b1;
      tick();
      bus.redirect_valid = 1'b0;
      n_vec++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL drain_quiet: got req %b inst %b expected 0 0", bus.imem_req_valid, bus.inst_valid); end
      bus.imem_req_ready = 1'b1;
      for (int k = 0; k < 30 && cons_pc.size() <= c0; k++) tick();
      n_vec++; if (cons_pc.size() <= c0) begin n_err++; $display("FAIL drain_timeout: got %0d instructions expected >= 1", cons_pc.size() - c0); end
      n_vec++; if (cons_pc[c0] !== 32'h8000_0100) begin n_err++; $display("FAIL drain_first_pc: got %h expected 80000100", cons_pc[c0]); end
      n_vec++; if (cons_data[c0] !== mem_word(32'h8000_0100)) begin n_err++; $display("FAIL drain_first_data: got %h expected %h", cons_data[c0], mem_word(32'h8000_0100)); end
      n_vec++; if (acc_q[a0+2] !== 32'h8000_0100) begin n_err++; $display("FAIL drain_next_req: got %h expected 80000100", acc_q[a0+2]); end
   endtask

   task automatic test_collision();
      int c0;
      repeat (4) tick();
      c0 = cons_pc.size();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0200;
      tick();
      bus.redirect_valid = 1'b0;
      n_vec++; if (edge_rsp !== 1'b1 || edge_hs !== 1'b1) begin n_err++; $display("FAIL coll_precond: got rsp %b hs %b expected 1 1", edge_rsp, edge_hs); end
      n_vec++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL coll_flush: got inst_valid %b expected 0", bus.inst_valid); end
      n_vec++; if (cons_pc.size() != c0) begin n_err++; $display("FAIL coll_pop_ignored: got %0d pops expected 0", cons_pc.size() - c0); end
      for (int k = 0; k < 30 && cons_pc.size() <= c0; k++) tick();
      n_vec++; if (cons_pc[c0] !== 32'h8000_0200) begin n_err++; $display("FAIL coll_next_pc: got %h expected 80000200", cons_pc[c0]); end
   endtask

   task automatic test_wrap();
      int a0;
      int c0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      a0 = acc_q.size();
      c0 = cons_pc.size();
      for (int k = 0; k < 30 && (acc_q.size() < a0 + 3 || cons_pc.size() < c0 + 2); k++) tick();
      n_vec++; if (acc_q[a0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req0: got %h expected fffffffc", acc_q[a0]); end
      n_vec++; if (acc_q[a0+1] !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_req1: got %h expected 00000000", acc_q[a0+1]); end
      n_vec++; if (acc_q[a0+2] !== 32'h0000_0004) begin n_err++; $display("FAIL wrap_req2: got %h expected 00000004", acc_q[a0+2]); end
      n_vec++; if (cons_pc[c0] !== 32'hFFFF_FFFC || cons_pc[c0+1] !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_inst_pc: got %h %h expected fffffffc 00000000", cons_pc[c0], cons_pc[c0+1]); end
   endtask

   task automatic test_misalign();
      int a0;
      int c0;
`ifdef RV32I_FETCH_MISALIGN_EN
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_0002;
      tick();
      bus.redirect_valid = 1'b0;
      a0 = acc_q.size();
      for (int k = 0; k < 30 && bus.inst_valid !== 1'b1; k++) tick();
      n_vec++; if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got valid %b fault %b expected 1 1", bus.inst_valid, bus.inst_fault); end
      n_vec++; if (bus.inst_pc !== 32'h8000_0002) begin n_err++; $display("FAIL mis_pc: got %h expected 80000002", bus.inst_pc); end
      n_vec++; if (bus.inst_data !== 32'h0000_0013) begin n_err++; $display("FAIL mis_data: got %h expected 00000013", bus.inst_data); end
      repeat (10) tick();
      n_vec++; if (acc_q.size() != a0 || bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mis_halt: got %0d requests valid %b expected 0 0", acc_q.size() - a0, bus.imem_req_valid); end
      bus.inst_ready = 1'b1;
      tick();
      n_vec++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL mis_single: got inst_valid %b expected 0", bus.inst_valid); end
      bus.redirect_pc = 32'h8000_0000;
`else
      bus.redirect_pc = 32'h8000_0002;
`endif
      bus.redirect_valid = 1'b1;
      tick();
      bus.redirect_valid = 1'b0;
      a0 = acc_q.size();
      c0 = cons_pc.size();
      for (int k = 0; k < 30 && cons_pc.size() <= c0; k++) tick();
      n_vec++; if (acc_q[a0] !== 32'h8000_0000) begin n_err++; $display("FAIL mis_resume_req: got %h expected 80000000", acc_q[a0]); end
      n_vec++; if (cons_pc[c0] !== 32'h8000_0000 || cons_fault[c0] !== 1'b0) begin n_err++; $display("FAIL mis_resume_inst: got pc %h fault %b expected 80000000 0", cons_pc[c0], cons_fault[c0]); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drain();
      test_collision();
      test_wrap();
      test_misalign();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end
endmodule
